// File: rtl/xsp_round_engine_if.sv
// Handshake bundle for the XSP round engine: block/key/mode input channel and result output channel.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready on the input side, out_valid/out_ready on the output side.
// Ports: in_valid/in_ready/in_data/in_key/in_mode (source -> engine),
//        out_valid/out_ready/out_data (engine -> sink), busy (engine status).
// Modports: slave = engine side, master = source/sink side.
interface xsp_round_engine_if #(
    parameter int DATA_W = 8
) ();
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] in_key;
    logic              in_mode;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              busy;

    modport slave (
        input  in_valid, in_data, in_key, in_mode, out_ready,
        output in_ready, out_valid, out_data, busy
    );

    modport master (
        output in_valid, in_data, in_key, in_mode, out_ready,
        input  in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/xsp_round_engine.sv
// Iterative multi-round XOR-Shift-Permutation cipher for 8-bit blocks, one round per clock.
// Latency: block accepted at edge N, result valid after edge N+ROUNDS.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, nothing is dropped.
// Ports: clk, rst_n (async active-low); io (slave modport of xsp_round_engine_if):
//        in_valid/in_ready/in_data/in_key/in_mode, out_valid/out_ready/out_data, busy.
// Build option: XSP_KEY_SCHEDULE_EN defined -> per-round key rk_r = rotl(key, r mod 8) ^ r;
//               undefined -> every round uses the latched key unchanged (same latency).
module xsp_round_engine #(
    parameter int ROUNDS = 4,
    parameter int DATA_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    xsp_round_engine_if.slave  io
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Highest round index; decrypt starts here and counts down.
    localparam logic [7:0] LAST_RND = 8'(ROUNDS - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] x_q, x_d;
    logic [DATA_W-1:0] key_q, key_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              mode_q, mode_d;
    logic [7:0]        cnt_q, cnt_d;

    logic [7:0]        rk;
    logic [7:0]        enc_x;
    logic [7:0]        dec_x;
    logic [7:0]        rnd_x;
    logic              last_rnd;

    function automatic logic [7:0] rotl8(input logic [7:0] v, input logic [2:0] n);
        logic [15:0] t;
        t = {v, v} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] rotl3(input logic [7:0] v);
        return {v[4:0], v[7:5]};
    endfunction

    function automatic logic [7:0] rotr3(input logic [7:0] v);
        return {v[2:0], v[7:3]};
    endfunction

    function automatic logic [7:0] bitrev(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = v[7-i];
        end
        return r;
    endfunction

    // Round key for the round currently indexed by the counter.
    always_comb begin
        rk = key_q;
`ifdef XSP_KEY_SCHEDULE_EN
        rk = rotl8(key_q, cnt_q[2:0]) ^ cnt_q;
`else
        rk = key_q;
`endif
    end

    // Decrypt is the exact inverse of the encrypt round: undo P, undo rotl3, undo XOR.
    assign enc_x    = bitrev(rotl3(x_q ^ rk));
    assign dec_x    = rotr3(bitrev(x_q)) ^ rk;
    assign rnd_x    = mode_q ? dec_x : enc_x;
    assign last_rnd = mode_q ? (cnt_q == 8'd0) : (cnt_q == LAST_RND);

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        key_d      = key_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    x_d     = io.in_data;
                    key_d   = io.in_key;
                    mode_d  = io.in_mode;
                    cnt_d   = io.in_mode ? LAST_RND : 8'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                x_d = rnd_x;
                if (last_rnd) begin
                    // Result goes to a dedicated register so out_data stays put
                    // after the transfer while x_q is reused by the next block.
                    out_data_d = rnd_x;
                    state_d    = DONE;
                end else begin
                    cnt_d = mode_q ? (cnt_q - 8'd1) : (cnt_q + 8'd1);
                end
            end
            DONE: begin
                if (io.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            x_q        <= '0;
            key_q      <= '0;
            mode_q     <= 1'b0;
            cnt_q      <= 8'd0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            key_q      <= key_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
        end
    end

    assign io.in_ready  = (state_q == IDLE);
    assign io.out_valid = (state_q == DONE);
    assign io.busy      = (state_q != IDLE);
    assign io.out_data  = out_data_q;

endmodule
